// File: rtl/div_ratio_checker_if.sv
// Control/result bus of the divider ratio checker. The master issues start and
// div_in; the slave (the checker) returns status, results and its FSM state.
interface div_ratio_checker_if #(
  parameter int WIN     = 10,
  parameter int TIMEOUT = 31
);
  localparam int TW = $clog2(WIN * TIMEOUT + 1);
  localparam int PW = $clog2(TIMEOUT + 1);

  // start is a one-cycle request honoured only while the checker is idle (busy=0
  // and no done pulse); done is a one-cycle pulse marking valid results, which
  // then hold until the next accepted start.
  logic          div_in;
  logic          start;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout_err;
  logic [TW-1:0] total;
  logic [PW-1:0] min_per;
  logic [PW-1:0] max_per;
  logic [1:0]    dbg_state;

  modport master (
    output div_in, start,
    input  busy, done, pass, timeout_err, total, min_per, max_per, dbg_state
  );

  modport slave (
    input  div_in, start,
    output busy, done, pass, timeout_err, total, min_per, max_per, dbg_state
  );
endinterface

// File: rtl/div_ratio_checker.sv
// Timestamps rising edges of a divided clock over WIN periods and reports total,
// min/max period and a verdict against the expected fractional ratio.
module div_ratio_checker #(
  parameter int WIN       = 10,
  parameter int EXP_TOTAL = 87,
  parameter int TIMEOUT   = 31
) (
  input  logic                clk,
  input  logic                rst_n,
  div_ratio_checker_if.slave  bus
);
  localparam int TW = $clog2(WIN * TIMEOUT + 1);
  localparam int PW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(WIN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_MEAS = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_div_d;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic          r_timeout_err;
  logic [TW-1:0] r_total;
  logic [PW-1:0] r_min_per;
  logic [PW-1:0] r_max_per;
  logic [PW-1:0] r_per_cnt;
  logic [CW-1:0] r_edge_cnt;

  logic          w_edge;
  logic          w_per_limit;
  logic          w_last_edge;
  logic [TW-1:0] w_total_nx;
  logic [PW-1:0] w_min_nx;
  logic [PW-1:0] w_max_nx;
  logic [PW-1:0] w_spread_nx;
  logic          w_ratio_ok;

  assign w_edge      = bus.div_in & ~r_div_d;
  // The increment about to happen would bring per_cnt to TIMEOUT.
  assign w_per_limit = (r_per_cnt == PW'(TIMEOUT - 1));
  assign w_last_edge = (r_edge_cnt == CW'(WIN - 1));
  assign w_total_nx  = r_total + TW'(r_per_cnt);
  assign w_min_nx    = (r_per_cnt < r_min_per) ? r_per_cnt : r_min_per;
  assign w_max_nx    = (r_per_cnt > r_max_per) ? r_per_cnt : r_max_per;
  assign w_spread_nx = w_max_nx - w_min_nx;
  assign w_ratio_ok  = (w_total_nx == TW'(EXP_TOTAL)) && (w_spread_nx <= PW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_div_d       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_total       <= '0;
      r_min_per     <= '0;
      r_max_per     <= '0;
      r_per_cnt     <= '0;
      r_edge_cnt    <= '0;
    end else begin
      r_div_d <= bus.div_in;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state       <= S_ARM;
            r_busy        <= 1'b1;
            r_pass        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_total       <= '0;
            r_min_per     <= '1;
            r_max_per     <= '0;
            r_per_cnt     <= '0;
            r_edge_cnt    <= '0;
          end
        end
        S_ARM: begin
          // The first edge only opens the window; nothing is measured yet.
          if (w_edge) begin
            r_state   <= S_MEAS;
            r_per_cnt <= PW'(1);
          end else begin
            r_per_cnt <= r_per_cnt + PW'(1);
            if (w_per_limit) begin
              r_state       <= S_DONE;
              r_busy        <= 1'b0;
              r_done        <= 1'b1;
              r_timeout_err <= 1'b1;
              r_pass        <= 1'b0;
            end
          end
        end
        S_MEAS: begin
          if (w_edge) begin
            r_total    <= w_total_nx;
            r_min_per  <= w_min_nx;
            r_max_per  <= w_max_nx;
            r_per_cnt  <= PW'(1);
            r_edge_cnt <= r_edge_cnt + CW'(1);
            if (w_last_edge) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= w_ratio_ok;
            end
          end else begin
            r_per_cnt <= r_per_cnt + PW'(1);
            if (w_per_limit) begin
              r_state       <= S_DONE;
              r_busy        <= 1'b0;
              r_done        <= 1'b1;
              r_timeout_err <= 1'b1;
              r_pass        <= 1'b0;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.pass        = r_pass;
  assign bus.timeout_err = r_timeout_err;
  assign bus.total       = r_total;
  assign bus.min_per     = r_min_per;
  assign bus.max_per     = r_max_per;
  assign bus.dbg_state   = r_state;
endmodule
